im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter: BIG_ENDIAN, default 1, meaning: 1 = first byte of each word lands in bits [31:24]; 0 = first byte lands in bits [7:0].
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  one-cycle request to begin a program load.
REQ-005 Port: byte_in  input  8  incoming program byte.
REQ-006 Port: byte_valid  input  1  byte_in holds a byte.
REQ-007 Port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: im_we  output  1  instruction-memory write strobe.
REQ-009 Port: im_waddr  output  10  word address into instruction memory, bits [11:2] of the byte address.
REQ-010 Port: im_wdata  output  32  instruction word to write.
REQ-011 Port: cpu_hold  output  1  holds the CPU (PC and fetch) while a load is in progress.
REQ-012 Port: done  output  1  last load completed successfully.
REQ-013 Port: err  output  1  last load aborted on a bad length.

Function
REQ-014 Byte transfer occurs only in a cycle where byte_valid=1 and byte_ready=1; no other cycle consumes a byte.
REQ-015 Load stream format: 2-byte word count N, high byte first, then N words of 4 bytes each.
REQ-016 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-017 IDLE, DONE and ERR each go to LEN_HI on start=1.
- On that transition: clear done and err, set im_waddr=0, clear the byte counter.
REQ-018 LEN_HI captures N[15:8] on transfer, then goes to LEN_LO.
REQ-019 LEN_LO captures N[7:0] on transfer.
- If the completed N is 0 or greater than 1024: go to ERR.
- Otherwise: go to DATA.
REQ-020 DATA shifts each transferred byte into the word assembly register according to BIG_ENDIAN.
- The 4th byte of a word moves the state to WRITE.
REQ-021 WRITE lasts exactly one cycle.
- im_we=1, with im_waddr and im_wdata stable for the whole cycle.
REQ-022 Leaving WRITE:
- If words written equals N: go to DONE.
- Otherwise: increment im_waddr and go to DATA.
REQ-023 Latency: im_we asserts in the cycle immediately after the cycle that transfers a word's 4th byte.
REQ-024 byte_ready=1 only in LEN_HI, LEN_LO and DATA; it is 0 in IDLE, WRITE, DONE and ERR.
REQ-025 Minimum transfer rate is 4 bytes per 5 cycles; byte_valid gaps stall the state machine with no side effect.
REQ-026 im_we=0 in every state except WRITE.
REQ-027 cpu_hold=1 in LEN_HI, LEN_LO, DATA and WRITE; it is 0 in IDLE, DONE and ERR.
REQ-028 done=1 in DONE only; err=1 in ERR only. Each holds until the next start or reset.
REQ-029 start is ignored while cpu_hold=1; a load cannot be restarted mid-stream.
REQ-030 Address arithmetic: with N=1024, the last write goes to im_waddr=1023.
- im_waddr never wraps to 0 within a load.
- The word counter is 11 bits so that 1024 is representable.
REQ-031 Bytes presented in IDLE, DONE or ERR are not consumed.

Reset
REQ-032 rst_n=0 immediately forces, without waiting for clk:
- state IDLE, byte_ready=0, im_we=0, im_waddr=0, im_wdata=0;
- cpu_hold=0, done=0, err=0, N=0, byte counter=0.
REQ-033 Reset during DATA or WRITE abandons the load; words already written stay in memory and no further write occurs.
REQ-034 After rst_n deasserts, the loader stays in IDLE until start=1.

Verification
REQ-035 Single-word load: start, then bytes 00 01 12 34 56 78 streamed back-to-back, BIG_ENDIAN=1.
- Response: one im_we pulse with im_waddr=0, im_wdata=0x12345678.
- Then done=1 and cpu_hold=0.
REQ-036 Little-endian: same stream with BIG_ENDIAN=0.
- Response: im_wdata=0x78563412 at im_waddr=0.
REQ-037 Bad length: length bytes 00 00, then repeated with 04 01.
- Response: err=1, no im_we pulse, byte_ready=0 after the length bytes.
REQ-038 Full load, N=1024 with random byte_valid gaps.
- Response: 1024 im_we pulses at addresses 0..1023 in order with the correct data.
- Then done=1, and no pulse at address 0 after the first.
REQ-039 Back-pressure: byte_valid held at 1 through a 3-word load.
- Response: byte_ready=0 in each WRITE cycle, and no byte is lost or duplicated.
REQ-040 Mid-load reset: rst_n=0 after 2 of 3 words have been written.
- Response: all outputs return to reset values at once, and no 3rd im_we pulse appears.
- A subsequent start with 1 word writes address 0.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: streams a length-prefixed program into instruction memory
// while holding the CPU, then reports done or a length error.
module im_loader #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_we,
  output logic [9:0]  im_waddr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  state_t      state, state_nx;
  logic [15:0] n;
  logic [1:0]  bcnt;
  logic [10:0] wcnt;
  logic        xfer;
  logic        last;
  logic [15:0] n_full;

  assign xfer   = byte_valid & byte_ready;
  assign n_full = {n[15:8], byte_in};
  assign last   = (wcnt + 11'd1) == n[10:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) state_nx = LEN_HI;
      LEN_HI:
        if (xfer) state_nx = LEN_LO;
      LEN_LO:
        if (xfer) begin
          if (n_full == 16'd0 || n_full > 16'd1024)
            state_nx = ERR;
          else
            state_nx = DATA;
        end
      DATA:
        if (xfer && bcnt == 2'd3) state_nx = WRITE;
      WRITE:
        state_nx = last ? DONE : DATA;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    im_we      = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (1'b1)
      state == LEN_HI,
      state == LEN_LO,
      state == DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
      end
      state == WRITE: begin
        im_we    = 1'b1;
        cpu_hold = 1'b1;
      end
      state == DONE: done = 1'b1;
      state == ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      im_waddr <= '0;
      im_wdata <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR:
          if (start) begin
            n        <= '0;
            bcnt     <= '0;
            wcnt     <= '0;
            im_waddr <= '0;
          end
        LEN_HI:
          if (xfer) n[15:8] <= byte_in;
        LEN_LO:
          if (xfer) n[7:0] <= byte_in;
        DATA:
          if (xfer) begin
            bcnt <= bcnt + 2'd1;
            if (BIG_ENDIAN)
              im_wdata <= {im_wdata[23:0], byte_in};
            else
              im_wdata <= {byte_in, im_wdata[31:8]};
          end
        WRITE: begin
          wcnt <= wcnt + 11'd1;
          // hold the final address so a full 1024-word load never wraps
          if (!last) im_waddr <= im_waddr + 10'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: big- and little-endian instances share one stream,
// each checked against a queue of expected memory writes.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        rdy_b, we_b, hold_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] data_b;
  logic        rdy_l, we_l, hold_l, done_l, err_l;
  logic [9:0]  addr_l;
  logic [31:0] data_l;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q_be[$];
  wr_t q_le[$];

  int checks = 0;
  int errors = 0;
  logic [9:0]  last_b_addr = '0;
  logic [31:0] last_b_data = '0;
  logic [31:0] last_l_data = '0;

  always #5 clk = ~clk;

  im_loader #(.BIG_ENDIAN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy_b), .im_we(we_b), .im_waddr(addr_b),
    .im_wdata(data_b), .cpu_hold(hold_b),
    .done(done_b), .err(err_b)
  );

  im_loader #(.BIG_ENDIAN(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy_l), .im_we(we_l), .im_waddr(addr_l),
    .im_wdata(data_l), .cpu_hold(hold_l),
    .done(done_l), .err(err_l)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      cmp("ready_vs_we_b", rdy_b & we_b, 1'b0);
      cmp("ready_vs_we_l", rdy_l & we_l, 1'b0);
      if (we_b) begin
        cmp("we_hold_b", hold_b, 1'b1);
        if (q_be.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_we_b: addr %0d data %0h", addr_b, data_b);
        end else begin
          e = q_be.pop_front();
          cmp("addr_b", addr_b, e.a);
          cmp("data_b", data_b, e.d);
        end
        last_b_addr = addr_b;
        last_b_data = data_b;
      end
      if (we_l) begin
        if (q_le.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexp_we_l: addr %0d data %0h", addr_l, data_l);
        end else begin
          e = q_le.pop_front();
          cmp("addr_l", addr_l, e.a);
          cmp("data_l", data_l, e.d);
        end
        last_l_data = data_l;
      end
    end
  end

  task automatic push_words(input logic [7:0] s[$], input int nw);
    for (int w = 0; w < nw; w++) begin
      q_be.push_back('{a: 10'(w),
        d: {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]}});
      q_le.push_back('{a: 10'(w),
        d: {s[5+4*w], s[4+4*w], s[3+4*w], s[2+4*w]}});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!rdy_b && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: byte %0h", b);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input bit ok);
    int t;
    t = 0;
    while (!(done_b | err_b) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL end_timeout: done %0b err %0b", done_b, err_b);
    end
    cmp("end_done_b", done_b, ok);
    cmp("end_err_b", err_b, !ok);
    cmp("end_done_l", done_l, ok);
    cmp("end_hold_b", hold_b, 1'b0);
    cmp("end_ready_b", rdy_b, 1'b0);
    cmp("left_be", q_be.size(), 0);
    cmp("left_le", q_le.size(), 0);
  endtask

  task automatic load(input logic [7:0] s[$], input bit hold_valid,
                      input int start_at);
    int nn;
    int g;
    bit ok;
    nn = {s[0], s[1]};
    ok = (nn != 0) && (nn <= 1024);
    if (ok) push_words(s, nn);
    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      start = (i == start_at);
      g = 0;
      if (!hold_valid && $urandom_range(0, 3) == 0)
        g = int'($urandom_range(1, 2));
      send_byte(s[i], g);
      if (ok && i >= 2 && ((i - 2) % 4) == 3)
        cmp("latency_we", we_b, 1'b1);
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    wait_end(ok);
  endtask

  task automatic chk_reset(input string nm);
    cmp({nm, "_rdy"}, rdy_b, 1'b0);
    cmp({nm, "_we"}, we_b, 1'b0);
    cmp({nm, "_addr"}, addr_b, 10'd0);
    cmp({nm, "_data"}, data_b, 32'd0);
    cmp({nm, "_hold"}, hold_b, 1'b0);
    cmp({nm, "_done"}, done_b, 1'b0);
    cmp({nm, "_err"}, err_b, 1'b0);
    cmp({nm, "_data_l"}, data_l, 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    #3;
    chk_reset("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("idle_hold", hold_b, 1'b0);
    cmp("idle_ready", rdy_b, 1'b0);

    // single word, both byte orders
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    load(s, 1'b1, -1);
    cmp("single_be", last_b_data, 32'h12345678);
    cmp("single_le", last_l_data, 32'h78563412);
    cmp("single_addr", last_b_addr, 10'd0);

    // bad lengths, and bytes offered in ERR are refused
    s = '{8'h00, 8'h00};
    load(s, 1'b0, -1);
    byte_in    = 8'h5a;
    byte_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      cmp("err_refuse", rdy_b, 1'b0);
      cmp("err_hold", err_b, 1'b1);
    end
    byte_valid = 1'b0;
    s = '{8'h04, 8'h01};
    load(s, 1'b0, -1);

    // three words with valid held high and a start pulse mid-load
    s = '{8'h00, 8'h03};
    for (int i = 0; i < 12; i++) s.push_back(8'(i * 17 + 3));
    load(s, 1'b1, 5);

    // full 1024-word load with random valid gaps
    s = '{8'h04, 8'h00};
    for (int i = 0; i < 4096; i++) s.push_back(8'($urandom));
    load(s, 1'b0, -1);
    cmp("full_last_addr", last_b_addr, 10'd1023);

    // reset after two of three words
    s = '{8'h00, 8'h03};
    for (int i = 0; i < 12; i++) s.push_back(8'(8'hc0 + i));
    push_words(s, 2);
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(s[i], 0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    cmp("midrst_left", q_be.size(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cmp("post_rst_hold", hold_b, 1'b0);
    cmp("post_rst_we", we_b, 1'b0);
    s = '{8'h00, 8'h01, 8'ha1, 8'hb2, 8'hc3, 8'hd4};
    load(s, 1'b0, -1);
    cmp("after_rst_addr", last_b_addr, 10'd0);
    cmp("after_rst_data", last_b_data, 32'ha1b2c3d4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
